snes_poll_gen: RTL

Synthesizable console-side controller poller. It generates the periodic SNES/NES latch and clock waveform and samples one or more serial data lines into parallel words. The block is the RTL successor to the simulation-only latch/clock stimulus, and is parametrised in frame period, pulse widths, bit count and channel count. It sits between the controller-port pins and the TAS replay/compare logic.

---
 rtl/snes_poll_gen_if.sv | 39 +++
 rtl/snes_poll_gen.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/snes_poll_gen_if.sv
// snes_poll_gen_if -- bundle between the poller and its surroundings.
//
// Carries both the controller-port pin side and the parallel result side:
//   enable     : runs the frame timer
//   trigger    : manual poll request (honoured only with SNES_POLL_TRIGGER_EN)
//   snes_data  : NUM_CH serial data lines, active-low
//   snes_lat   : latch to controllers
//   snes_clk   : clock to controllers, idles high
//   poll_word  : NUM_CH*NUM_BITS captured buttons, 1 = pressed
//   poll_valid : one-cycle pulse when poll_word updates
//   busy       : poll in progress
//   overrun    : sticky, poll start requested while busy
//
// master modport: the poller.  slave modport: whoever drives enable/trigger,
// the pad lines and consumes the result.
interface snes_poll_gen_if #(
    parameter int unsigned NUM_BITS = 16,
    parameter int unsigned NUM_CH   = 2
);
    logic                         enable;
    logic                         trigger;
    logic [NUM_CH-1:0]            snes_data;
    logic                         snes_lat;
    logic                         snes_clk;
    logic [NUM_CH*NUM_BITS-1:0]   poll_word;
    logic                         poll_valid;
    logic                         busy;
    logic                         overrun;

    modport master (
        input  enable, trigger, snes_data,
        output snes_lat, snes_clk, poll_word, poll_valid, busy, overrun
    );

    modport slave (
        output enable, trigger, snes_data,
        input  snes_lat, snes_clk, poll_word, poll_valid, busy, overrun
    );
endinterface

// File: rtl/snes_poll_gen.sv
// snes_poll_gen -- console-side SNES/NES controller poller.
//
// Generates the periodic latch/clock waveform and samples NUM_CH serial data
// lines into a parallel word once per frame.
//
// Ports:
//   sys_clk : system clock
//   rst_n   : asynchronous active-low reset
//   bus     : snes_poll_gen_if.master (enable, trigger, snes_data in;
//             snes_lat, snes_clk, poll_word, poll_valid, busy, overrun out)
//
// Build option: define SNES_POLL_TRIGGER_EN to honour bus.trigger as a manual
// poll request (also reloads the frame timer). Without it trigger is ignored.
//
// snes_data is consumed unsynchronised; the pad wrapper owns synchronisation.
module snes_poll_gen #(
    parameter int unsigned FRAME_CYCLES = 793651,
    parameter int unsigned LATCH_CYCLES = 572,
    parameter int unsigned HALF_CYCLES  = 286,
    parameter int unsigned NUM_BITS     = 16,
    parameter int unsigned NUM_CH       = 2
) (
    input  logic             sys_clk,
    input  logic             rst_n,
    snes_poll_gen_if.master  bus
);

    localparam int unsigned FC_W   = (FRAME_CYCLES > 1) ? $clog2(FRAME_CYCLES) : 1;
    localparam int unsigned LAT_W  = (LATCH_CYCLES > 1) ? $clog2(LATCH_CYCLES) : 1;
    localparam int unsigned HALF_W = (HALF_CYCLES  > 1) ? $clog2(HALF_CYCLES)  : 1;
    localparam int unsigned PH_W   = (LAT_W > HALF_W) ? LAT_W : HALF_W;
    localparam int unsigned PC_W   = (NUM_BITS > 1) ? $clog2(NUM_BITS) : 1;

    localparam logic [FC_W-1:0] FC_LAST   = FC_W'(FRAME_CYCLES - 1);
    localparam logic [PH_W-1:0] LAT_LAST  = PH_W'(LATCH_CYCLES - 1);
    localparam logic [PH_W-1:0] HALF_LAST = PH_W'(HALF_CYCLES - 1);
    localparam logic [PC_W-1:0] PC_LAST   = PC_W'(NUM_BITS - 1);

    typedef enum logic [2:0] {
        IDLE,
        LATCH,
        CLK_LO,
        CLK_HI,
        DONE
    } state_t;

    state_t state, state_nxt;

    logic [FC_W-1:0]                  fc, fc_nxt;
    logic [PH_W-1:0]                  cnt, cnt_nxt;
    logic [PC_W-1:0]                  pc, pc_nxt;
    logic [NUM_CH-1:0][NUM_BITS-1:0]  shadow, shadow_nxt;
    logic [NUM_BITS:0]                shifted;

    logic tick_req;
    logic trig_req;
    logic start_req;
    logic sample;

    // ------------------------------------------------------------------
    // Poll start requests
    // ------------------------------------------------------------------
`ifdef SNES_POLL_TRIGGER_EN
    assign trig_req = bus.trigger;
`else
    logic unused_trigger;
    assign unused_trigger = bus.trigger;
    assign trig_req       = 1'b0;
`endif

    assign tick_req  = bus.enable && (fc == '0);
    assign start_req = tick_req || trig_req;

    // Frame timer. A trigger accepted in IDLE re-phases the frame so the next
    // periodic poll lands FRAME_CYCLES after the trigger.
    always_comb begin
        fc_nxt = fc;
        if (!bus.enable) begin
            fc_nxt = '0;
        end else if (trig_req && (state == IDLE)) begin
            fc_nxt = FC_W'(1);
        end else if (fc == FC_LAST) begin
            fc_nxt = '0;
        end else begin
            fc_nxt = fc + FC_W'(1);
        end
    end

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state, phase/pulse counters, sampling strobe
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        pc_nxt    = pc;
        sample    = 1'b0;

        unique case (state)
            IDLE: begin
                if (start_req) begin
                    state_nxt = LATCH;
                    cnt_nxt   = '0;
                end
            end
            LATCH: begin
                if (cnt == LAT_LAST) begin
                    sample    = 1'b1;
                    state_nxt = CLK_LO;
                    cnt_nxt   = '0;
                    pc_nxt    = '0;
                end else begin
                    cnt_nxt = cnt + PH_W'(1);
                end
            end
            CLK_LO: begin
                if (cnt == HALF_LAST) begin
                    state_nxt = CLK_HI;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + PH_W'(1);
                end
            end
            CLK_HI: begin
                if (cnt == HALF_LAST) begin
                    cnt_nxt = '0;
                    // pc counts completed pulses; the final pulse samples nothing.
                    if (pc == PC_LAST) begin
                        state_nxt = DONE;
                    end else begin
                        sample    = 1'b1;
                        pc_nxt    = pc + PC_W'(1);
                        state_nxt = CLK_LO;
                    end
                end else begin
                    cnt_nxt = cnt + PH_W'(1);
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Shadow shifts right with the new inverted sample entering at the MSB, so
    // after NUM_BITS samples the first one shifted out sits in bit 0.
    always_comb begin
        shadow_nxt = shadow;
        shifted    = '0;
        if (sample) begin
            for (int unsigned c = 0; c < NUM_CH; c++) begin
                shifted       = {~bus.snes_data[c], shadow[c]};
                shadow_nxt[c] = shifted[NUM_BITS:1];
            end
        end
    end

    // ------------------------------------------------------------------
    // Datapath and registered outputs (decoded from the next state so they
    // line up with the state register)
    // ------------------------------------------------------------------
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            fc             <= '0;
            cnt            <= '0;
            pc             <= '0;
            shadow         <= '0;
            bus.snes_lat   <= 1'b0;
            bus.snes_clk   <= 1'b1;
            bus.poll_word  <= '0;
            bus.poll_valid <= 1'b0;
            bus.busy       <= 1'b0;
            bus.overrun    <= 1'b0;
        end else begin
            fc             <= fc_nxt;
            cnt            <= cnt_nxt;
            pc             <= pc_nxt;
            shadow         <= shadow_nxt;
            bus.snes_lat   <= (state_nxt == LATCH);
            bus.snes_clk   <= (state_nxt != CLK_LO);
            bus.poll_valid <= (state_nxt == DONE);
            bus.busy       <= (state_nxt != IDLE);
            if (state_nxt == DONE) begin
                bus.poll_word <= shadow;
            end
            if (start_req && (state != IDLE)) begin
                bus.overrun <= 1'b1;
            end
        end
    end

endmodule
